// File: rtl/mio_timer_pkg.sv
// Shared definitions for the MIO timer bank: register map, mode encodings
// and the CTRL register layout.
package mio_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_FREERUN  = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IE_BIT   = 3;
    localparam int CTRL_BITS     = 4;

    // Packed so that a cast of CTRL[3:0] lands each field on its bit position.
    typedef struct packed {
        logic       ie;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/mio_timer_bank_if.sv
// MIO bus port of the timer bank: single-cycle write strobe plus a
// combinational read path selected by the word address.
interface mio_timer_bank_if #(
    parameter int ADDR_W = 4
) ();
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/mio_timer_ch.sv
// One timer channel: CTRL/LOAD/COUNT/flag storage and the per-mode
// count behaviour. A bus write to CTRL/LOAD/COUNT takes priority over the tick.
module mio_timer_ch
    import mio_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [1:0]       wr_reg,
    input  logic [31:0]      wdata,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             flag
);

    ctrl_t            ctrl_nxt;
    logic [WIDTH-1:0] load_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             flag_nxt;
    logic             expire;
    logic             cfg_wr;
    logic             flag_clr;
    logic             unused_wdata;

    assign cfg_wr       = wr_en && (wr_reg != REG_STATUS);
    assign flag_clr     = wr_en && (wr_reg == REG_STATUS) && wdata[0];
    assign unused_wdata = ^wdata;

    // Next-state: bus write first, otherwise the tick advances by mode.
    always_comb begin
        ctrl_nxt  = ctrl;
        load_nxt  = load;
        count_nxt = count;
        expire    = 1'b0;
        if (cfg_wr) begin
            case (wr_reg)
                REG_CTRL:  ctrl_nxt = ctrl_t'(wdata[CTRL_BITS-1:0]);
                REG_LOAD: begin
                    load_nxt  = wdata[WIDTH-1:0];
                    count_nxt = wdata[WIDTH-1:0];
                end
                REG_COUNT: count_nxt = wdata[WIDTH-1:0];
                default:   ;
            endcase
        end else if (tick && ctrl.en) begin
            case (ctrl.mode)
                MODE_ONESHOT: begin
                    if (count > WIDTH'(1)) begin
                        count_nxt = count - WIDTH'(1);
                    end else begin
                        count_nxt   = '0;
                        expire      = 1'b1;
                        ctrl_nxt.en = 1'b0;
                    end
                end
                MODE_PERIODIC: begin
                    if (count > WIDTH'(1)) begin
                        count_nxt = count - WIDTH'(1);
                    end else begin
                        count_nxt = load;
                        expire    = 1'b1;
                    end
                end
                MODE_FREERUN: begin
                    count_nxt = count + WIDTH'(1);
                    expire    = &count;
                end
                default: ;
            endcase
        end
        // A fresh expiry outranks a simultaneous write-1-to-clear.
        flag_nxt = expire | (flag & ~flag_clr);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            flag  <= 1'b0;
        end else begin
            ctrl  <= ctrl_nxt;
            load  <= load_nxt;
            count <= count_nxt;
            flag  <= flag_nxt;
        end
    end

endmodule

// File: rtl/mio_timer_bank.sv
// Multi-channel MIO timer/counter: shared prescaler, NUM_CH channels,
// register read mux and interrupt aggregation.
module mio_timer_bank
    import mio_timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 0,
    parameter int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    mio_timer_bank_if.slave   bus,
    output logic [NUM_CH-1:0] irq,
    output logic              int_out,
    output logic [WIDTH-1:0]  count0_out
);

    logic               tick;
    logic [1:0]         reg_sel;
    logic [CH_BITS-1:0] ch_sel;
    logic [31:0]        rdata_mux;

    ctrl_t              ch_ctrl  [NUM_CH];
    logic [WIDTH-1:0]   ch_load  [NUM_CH];
    logic [WIDTH-1:0]   ch_count [NUM_CH];
    logic [NUM_CH-1:0]  ch_flag;

    assign reg_sel = bus.addr[1:0];
    assign ch_sel  = bus.addr[CH_BITS+1:2];

    if (PRESCALE == 0) begin : g_no_ps
        assign tick = 1'b1;
    end else begin : g_ps
        localparam int PS_W = $clog2(PRESCALE + 1);
        logic [PS_W-1:0] ps_cnt;

        assign tick = (ps_cnt == PS_W'(PRESCALE));

        // Prescaler counts 0..PRESCALE; tick marks the wrap.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ps_cnt <= '0;
            end else if (tick) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + PS_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mio_timer_ch #(.WIDTH(WIDTH)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .wr_en  (bus.we && (ch_sel == CH_BITS'(g))),
            .wr_reg (reg_sel),
            .wdata  (bus.wdata),
            .ctrl   (ch_ctrl[g]),
            .load   (ch_load[g]),
            .count  (ch_count[g]),
            .flag   (ch_flag[g])
        );
        assign irq[g] = ch_flag[g] & ch_ctrl[g].ie;
    end

    // Read mux; channel indices past NUM_CH match nothing and read zero.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_BITS'(i)) begin
                case (reg_sel)
                    REG_CTRL:  rdata_mux = {28'd0, ch_ctrl[i]};
                    REG_LOAD:  rdata_mux = 32'(ch_load[i]);
                    REG_COUNT: rdata_mux = 32'(ch_count[i]);
                    default:   rdata_mux = {31'd0, ch_flag[i]};
                endcase
            end
        end
    end

    assign bus.rdata  = rdata_mux;
    assign int_out    = |irq;
    assign count0_out = ch_count[0];

endmodule

// File: tb/tb_mio_timer_bank.sv
// Bench for mio_timer_bank: two builds (4ch/32b/no prescale and
// 2ch/8b/prescale 3 with a 2-bit channel field) against a behavioural model.
module tb_mio_timer_bank;
    import mio_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mio_timer_bank_if #(.ADDR_W(4)) bus_a ();
    mio_timer_bank_if #(.ADDR_W(4)) bus_b ();

    logic [3:0]  irq_a;
    logic [1:0]  irq_b;
    logic        int_a, int_b;
    logic [31:0] cnt0_a;
    logic [7:0]  cnt0_b;

    mio_timer_bank #(.NUM_CH(4), .WIDTH(32), .PRESCALE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .irq(irq_a), .int_out(int_a), .count0_out(cnt0_a));

    mio_timer_bank #(.NUM_CH(2), .WIDTH(8), .PRESCALE(3), .CH_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .irq(irq_b), .int_out(int_b), .count0_out(cnt0_b));

    // ---------------- reference model ----------------
    int unsigned     ps_lim [2] = '{0, 3};
    int              nch    [2] = '{4, 2};
    longint unsigned msk    [2] = '{64'hFFFF_FFFF, 64'hFF};

    bit              m_en   [2][4];
    bit [1:0]        m_mode [2][4];
    bit              m_ie   [2][4];
    bit              m_flag [2][4];
    longint unsigned m_load [2][4];
    longint unsigned m_cnt  [2][4];
    int unsigned     m_pc   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0;
            for (int c = 0; c < 4; c++) begin
                m_en[d][c] = 0; m_mode[d][c] = 0; m_ie[d][c] = 0; m_flag[d][c] = 0;
                m_load[d][c] = 0; m_cnt[d][c] = 0;
            end
        end
    endtask

    // Advance one clock of build d given the bus inputs present in that cycle.
    task automatic m_step(int d, bit we, int a, longint unsigned wd);
        bit tick;
        int ch, r;
        ch   = a / 4;
        r    = a % 4;
        tick = (m_pc[d] == ps_lim[d]);
        m_pc[d] = tick ? 0 : m_pc[d] + 1;
        for (int c = 0; c < nch[d]; c++) begin
            bit hit, set;
            hit = we && (ch == c);
            set = 0;
            if (tick && m_en[d][c] && !(hit && r != 3)) begin
                case (m_mode[d][c])
                    2'b00: if (m_cnt[d][c] > 1) m_cnt[d][c]--;
                           else begin m_cnt[d][c] = 0; set = 1; m_en[d][c] = 0; end
                    2'b01: if (m_cnt[d][c] > 1) m_cnt[d][c]--;
                           else begin m_cnt[d][c] = m_load[d][c]; set = 1; end
                    2'b10: begin
                        m_cnt[d][c] = (m_cnt[d][c] + 1) & msk[d];
                        if (m_cnt[d][c] == 0) set = 1;
                    end
                    default: ;
                endcase
            end
            if (hit) begin
                case (r)
                    0: begin m_en[d][c] = wd[0]; m_mode[d][c] = wd[2:1]; m_ie[d][c] = wd[3]; end
                    1: begin m_load[d][c] = wd & msk[d]; m_cnt[d][c] = wd & msk[d]; end
                    2: m_cnt[d][c] = wd & msk[d];
                    default: if (wd[0]) m_flag[d][c] = 0;
                endcase
            end
            if (set) m_flag[d][c] = 1;
        end
    endtask

    function automatic longint unsigned m_read(int d, int a);
        int ch, r;
        ch = a / 4;
        r  = a % 4;
        if (ch >= nch[d]) return 0;
        case (r)
            0: return longint'(m_ie[d][ch]) * 8 + longint'(m_mode[d][ch]) * 2 + longint'(m_en[d][ch]);
            1: return m_load[d][ch];
            2: return m_cnt[d][ch];
            default: return longint'(m_flag[d][ch]);
        endcase
    endfunction

    function automatic longint unsigned m_irq(int d);
        longint unsigned v = 0;
        for (int c = 0; c < nch[d]; c++)
            if (m_flag[d][c] && m_ie[d][c]) v |= (64'd1 << c);
        return v;
    endfunction

    // ---------------- bus helpers ----------------
    task automatic drive(int d, bit we, int a, longint unsigned wd);
        if (d == 0) begin bus_a.we = we; bus_a.addr = 4'(a); bus_a.wdata = 32'(wd); end
        else        begin bus_b.we = we; bus_b.addr = 4'(a); bus_b.wdata = 32'(wd); end
    endtask

    task automatic rd_val(int d, int a, output logic [31:0] v);
        if (d == 0) begin bus_a.addr = 4'(a); #1 v = bus_a.rdata; end
        else        begin bus_b.addr = 4'(a); #1 v = bus_b.rdata; end
    endtask

    task automatic rd_chk(string tag, int d, int a);
        logic [31:0] v;
        rd_val(d, a, v);
        check(tag, v, m_read(d, a));
    endtask

    task automatic step();
        m_step(0, bus_a.we, int'(bus_a.addr), longint'(bus_a.wdata));
        m_step(1, bus_b.we, int'(bus_b.addr), longint'(bus_b.wdata));
        @(posedge clk);
        #1;
        cyc++;
        bus_a.we = 1'b0;
        bus_b.we = 1'b0;
        check("irq_a",  irq_a,  m_irq(0));
        check("int_a",  int_a,  64'(m_irq(0) != 0));
        check("cnt0_a", cnt0_a, m_cnt[0][0]);
        check("irq_b",  irq_b,  m_irq(1));
        check("int_b",  int_b,  64'(m_irq(1) != 0));
        check("cnt0_b", cnt0_b, m_cnt[1][0]);
        rd_chk("rd_a", 0, int'($urandom_range(0, 15)));
        rd_chk("rd_b", 1, int'($urandom_range(0, 15)));
    endtask

    task automatic wr(int d, int a, longint unsigned wd);
        drive(d, 1'b1, a, wd);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int rises, last;
        bit prev;

        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        rd_chk("rst_ctrl_a", 0, 0);
        check("rst_int_a", int_a, 0);
        check("rst_cnt0_a", cnt0_a, 0);

        // one-shot countdown on build A channel 0
        wr(0, 1, 3);
        check("os_load", cnt0_a, 3);
        wr(0, 0, 9);
        check("os_start", cnt0_a, 3);
        step(); check("os_c2", cnt0_a, 2);
        step(); check("os_c1", cnt0_a, 1);
        check("os_noint", int_a, 0);
        step(); check("os_c0", cnt0_a, 0);
        check("os_int", int_a, 1);
        rd_val(0, 0, v); check("os_ctrl", v, 8);
        repeat (3) step();
        check("os_hold", cnt0_a, 0);
        wr(0, 3, 1);
        check("os_clr", int_a, 0);

        // write during tick, freeze and resume
        wr(0, 2, 10);
        wr(0, 0, 9);
        step(); check("fz_c9", cnt0_a, 9);
        wr(0, 2, 5); check("fz_wr5", cnt0_a, 5);
        step(); check("fz_c4", cnt0_a, 4);
        wr(0, 0, 8); check("fz_stop", cnt0_a, 4);
        repeat (20) step();
        check("fz_frozen", cnt0_a, 4);
        wr(0, 0, 9); check("fz_reen", cnt0_a, 4);
        step(); check("fz_resume", cnt0_a, 3);
        wr(0, 0, 8);

        // free-run wrap on channel 2, interrupt disabled
        wr(0, 10, 64'hFFFF_FFFE);
        wr(0, 8, 5);
        rd_val(0, 10, v); check("fr_fe", v, 32'hFFFF_FFFE);
        step(); rd_val(0, 10, v); check("fr_ff", v, 32'hFFFF_FFFF);
        step(); rd_val(0, 10, v); check("fr_wrap", v, 0);
        rd_val(0, 11, v); check("fr_flag", v, 1);
        check("fr_irq2", irq_a[2], 0);
        check("fr_int", int_a, 0);
        wr(0, 8, 0);
        wr(0, 11, 1);

        // periodic with prescaler on build B channel 1
        wr(1, 5, 2);
        wr(1, 4, 11);
        rises = 0; last = 0;
        prev = irq_b[1];
        for (int i = 0; i < 40 && rises < 3; i++) begin
            step();
            if (irq_b[1] && !prev) begin
                if (rises > 0) check("per_gap", 64'(cyc - last), 8);
                rises++;
                last = cyc;
                wr(1, 7, 1);
                check("per_clr", irq_b[1], 0);
            end
            prev = irq_b[1];
        end
        check("per_rises", 64'(rises), 3);
        while (cyc < last + 7) step();
        wr(1, 7, 1);
        check("w1c_vs_set", irq_b[1], 1);
        rd_val(1, 7, v); check("w1c_vs_set_rd", v, 1);
        wr(1, 4, 0);
        wr(1, 7, 1);

        // channel index beyond NUM_CH on build B
        for (int r = 0; r < 4; r++) begin
            wr(1, 12 + r, 64'hFFFF_FFFF);
            rd_val(1, 12 + r, v); check("oob_rd", v, 0);
        end
        rd_val(1, 5, v); check("oob_load1", v, 2);
        rd_val(1, 4, v); check("oob_ctrl1", v, 0);

        // randomized traffic on both builds
        for (int i = 0; i < 500; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int a;
                    longint unsigned wd;
                    a = int'($urandom_range(0, 15));
                    case (a % 4)
                        0: wd = $urandom_range(0, 15);
                        3: wd = $urandom;
                        default: wd = ($urandom_range(0, 3) == 0) ? longint'($urandom)
                                                                  : longint'($urandom_range(0, 6));
                    endcase
                    drive(d, 1'b1, a, wd);
                end
            end
            step();
        end

        // async reset mid-cycle with a write pending and channels running
        wr(0, 1, 77);
        wr(0, 0, 9);
        wr(1, 1, 5);
        wr(1, 0, 9);
        drive(0, 1'b1, 2, 55);
        @(negedge clk);
        #2 rst = 1'b0;
        m_reset();
        #1;
        check("ar_cnt0_a", cnt0_a, 0);
        check("ar_int_a", int_a, 0);
        check("ar_int_b", int_b, 0);
        check("ar_irq_a", irq_a, 0);
        rd_val(0, 1, v); check("ar_load_a", v, 0);
        rd_val(0, 0, v); check("ar_ctrl_a", v, 0);
        rd_val(1, 1, v); check("ar_load_b", v, 0);
        bus_a.we = 1'b0;
        repeat (2) @(posedge clk);
        check("ar_hold", cnt0_a, 0);
        #3 rst = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
